// File: rtl/debouncer_bank.sv
// -----------------------------------------------------------------------------
// debouncer_bank
//
// Multi-channel push-button debouncer running entirely on one clock. A shared
// prescaler produces a one-clk sampling strobe (a clock enable, never a derived
// clock). Each channel:
//   - optionally inverts its raw input (active-low buttons),
//   - passes it through a two-flop synchroniser,
//   - qualifies the synchronised value on sampling ticks: the published level
//     only changes after STABLE consecutive tick samples that all disagree
//     with it,
//   - emits registered one-clk rise/fall pulses when the level changes.
//
// Parameters
//   CHANNELS  number of independent button inputs
//   DIV       clk cycles per sampling tick (>= 2)
//   STABLE    consecutive differing samples needed to change the level (>= 1)
//   POLARITY  per-channel mask, bit=1 inverts that raw input
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   btn_raw    asynchronous raw button inputs
//   btn_level  debounced, polarity-corrected levels
//   btn_rise   one-clk pulse when btn_level goes 0->1
//   btn_fall   one-clk pulse when btn_level goes 1->0
//   tick       sampling strobe, one clk wide, period DIV
// -----------------------------------------------------------------------------
module debouncer_bank #(
  parameter int                    CHANNELS = 5,
  parameter int                    DIV      = 350,
  parameter int                    STABLE   = 3,
  parameter logic [CHANNELS-1:0]   POLARITY = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic                tick
);

  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(STABLE + 1);

  localparam logic [PW-1:0] LP_DIV_LAST = PW'(DIV - 1);
  // A channel commits on the sample that would make cnt reach STABLE, so the
  // counter only ever holds 0..STABLE-1.
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(STABLE - 1);

  // ---------------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_div;
  logic          w_tick;

  // NOTE: every register in this file is updated with non-blocking
  // assignments so all flops sample pre-edge values, as real hardware does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (r_div == LP_DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = (r_div == LP_DIV_LAST);
  assign tick   = w_tick;

  // ---------------------------------------------------------------------------
  // Polarity correction and two-flop synchroniser. The XOR sits in front of
  // the first flop so nothing combinational lies between s1 and s2.
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] r_s1;
  logic [CHANNELS-1:0] r_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw ^ POLARITY;
      r_s2 <= r_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel qualifier. Each channel owns its registers so no vector is
  // driven from more than one process.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

    // NOTE: the stable counters are reset along with everything else; a
    // reset in the middle of qualification must discard partial progress.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        // Pulses live for exactly one clk after the committing edge.
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (w_tick) begin
          if (r_s2[g] == r_level) begin
            // Any agreeing sample restarts qualification (bounce rejection).
            r_cnt <= '0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_level <= r_s2[g];
            r_cnt   <= '0;
            r_rise  <= r_s2[g];
            r_fall  <= ~r_s2[g];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end

    assign btn_level[g] = r_level;
    assign btn_rise[g]  = r_rise;
    assign btn_fall[g]  = r_fall;
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// -----------------------------------------------------------------------------
// tb_debouncer_bank
//
// Self-checking bench for debouncer_bank with CHANNELS=2, DIV=4, STABLE=3,
// POLARITY=2'b10. A behavioural model tracks, per edge, which input value the
// design sees at each sampling tick (input delayed by two clocks) and keeps a
// history of tick samples; the level flips once the last STABLE samples all
// disagree with it. Directed scenarios are followed by a randomised bounce run.
// -----------------------------------------------------------------------------
module tb_debouncer_bank;

  localparam int         CH     = 2;
  localparam int         DIV    = 4;
  localparam int         STABLE = 3;
  localparam logic [1:0] POL    = 2'b10;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [CH-1:0] btn_raw = 2'b10;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_rise;
  logic [CH-1:0] btn_fall;
  logic          tick;

  debouncer_bank #(
    .CHANNELS (CH),
    .DIV      (DIV),
    .STABLE   (STABLE),
    .POLARITY (POL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int            m_n;        // edges since reset release (edge 1 = first)
  logic [CH-1:0] m_xd1;      // corrected input at previous edge
  logic [CH-1:0] m_xd2;      // corrected input two edges back
  logic [CH-1:0] m_level;
  logic [CH-1:0] m_rise;
  logic [CH-1:0] m_fall;
  bit            m_hist [CH][$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n     = 0;
      m_xd1   = '0;
      m_xd2   = '0;
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int c = 0; c < CH; c++) m_hist[c].delete();
    end else begin
      m_n++;
      m_rise = '0;
      m_fall = '0;
      if (m_n % DIV == 0) begin
        for (int c = 0; c < CH; c++) begin
          bit all_differ;
          m_hist[c].push_back(m_xd2[c]);
          if (m_hist[c].size() > STABLE) void'(m_hist[c].pop_front());
          all_differ = (m_hist[c].size() == STABLE);
          foreach (m_hist[c][k]) if (m_hist[c][k] == m_level[c]) all_differ = 0;
          if (all_differ) begin
            m_level[c] = ~m_level[c];
            if (m_level[c]) m_rise[c] = 1'b1;
            else            m_fall[c] = 1'b1;
            m_hist[c].delete();
          end
        end
      end
      m_xd2 = m_xd1;
      m_xd1 = btn_raw ^ POL;
    end
  end

  // ---------------------------------------------------------------------------
  // Stepping and per-cycle comparison
  // ---------------------------------------------------------------------------
  int            n_pulse [CH];
  int            n_trans [CH];
  int            n_rise_seen [CH];
  int            n_fall_seen [CH];
  logic [CH-1:0] prev_level = '0;

  task automatic step();
    logic rst_at_edge;
    logic m_tick;
    rst_at_edge = rst_n;
    @(posedge clk);
    @(negedge clk);
    m_tick = rst_n && (m_n % DIV == DIV - 1);
    check("outputs", {25'd0, tick, btn_level, btn_rise, btn_fall},
                     {25'd0, m_tick, m_level, m_rise, m_fall});
    check("rise_fall_excl", {30'd0, btn_rise & btn_fall}, 32'd0);
    for (int c = 0; c < CH; c++) begin
      n_pulse[c]     += int'(btn_rise[c]) + int'(btn_fall[c]);
      n_rise_seen[c] += int'(btn_rise[c]);
      n_fall_seen[c] += int'(btn_fall[c]);
      if (rst_at_edge && btn_level[c] != prev_level[c]) n_trans[c]++;
    end
    prev_level = btn_level;
  endtask

  initial begin
    int r0, f1, r1, sim_hits;
    for (int c = 0; c < CH; c++) begin
      n_pulse[c] = 0; n_trans[c] = 0; n_rise_seen[c] = 0; n_fall_seen[c] = 0;
    end

    // Reset / idle: released buttons, nothing may move; tick after 3,7,11...
    rst_n   = 1'b0;
    btn_raw = 2'b10;
    repeat (3) step();
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      check("idle_out", {26'd0, btn_level, btn_rise, btn_fall}, 32'd0);
      check("idle_tick", {31'd0, tick}, {31'd0, (cyc % 4 == 3)});
    end

    // Clean press on ch0 from edge 1: level rises after edge 12.
    rst_n = 1'b0;
    step();
    btn_raw = 2'b11;
    rst_n   = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      check("press_level", {31'd0, btn_level[0]}, {31'd0, (cyc >= 12)});
      check("press_rise",  {31'd0, btn_rise[0]},  {31'd0, (cyc == 12)});
      check("press_fall",  {31'd0, btn_fall[0]},  32'd0);
    end

    // Release ch0, then bounce 1,0,1 over alternate ticks and hold high.
    btn_raw[0] = 1'b0;
    repeat (20) step();
    check("release_level", {31'd0, btn_level[0]}, 32'd0);
    r0 = n_rise_seen[0];
    btn_raw[0] = 1'b1; repeat (8) step();
    btn_raw[0] = 1'b0; repeat (8) step();
    btn_raw[0] = 1'b1; repeat (30) step();
    check("bounce_rises", n_rise_seen[0] - r0, 1);
    check("bounce_level", {31'd0, btn_level[0]}, 32'd1);

    // Active-low ch1: press (raw 0), then release (raw 1).
    r1 = n_rise_seen[1];
    f1 = n_fall_seen[1];
    btn_raw[1] = 1'b0; repeat (20) step();
    check("al_press_level", {31'd0, btn_level[1]}, 32'd1);
    check("al_press_rise",  n_rise_seen[1] - r1, 1);
    btn_raw[1] = 1'b1; repeat (20) step();
    check("al_release_level", {31'd0, btn_level[1]}, 32'd0);
    check("al_release_fall",  n_fall_seen[1] - f1, 1);

    // Reset mid-qualification: two qualifying ticks, then a 1-clk reset.
    rst_n = 1'b0;
    step();
    btn_raw = 2'b11;
    rst_n   = 1'b1;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    check("midrst_level", {30'd0, btn_level}, 32'd0);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      check("midrst_requal", {31'd0, btn_level[0]}, {31'd0, (cyc >= 12)});
    end

    // Simultaneous: ch0 released and ch1 pressed before the same tick.
    sim_hits = 0;
    btn_raw  = 2'b00;
    repeat (20) begin
      step();
      if (btn_fall[0] && btn_rise[1]) sim_hits++;
    end
    check("simultaneous", sim_hits, 1);

    // Randomised bounce run.
    for (int seg = 0; seg < 250; seg++) begin
      btn_raw = 2'($urandom);
      repeat ($urandom_range(1, 20)) step();
    end
    btn_raw = 2'b10;
    repeat (20) step();
    for (int c = 0; c < CH; c++) check("pulses_vs_transitions", n_pulse[c], n_trans[c]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
